// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int                DEF_MAX_LEN     = 8;
  localparam int                DEF_CNT_W       = 8;
  localparam logic [7:0]        DEF_RST_PATTERN = 8'b0000_0101;
  localparam int                DEF_RST_LEN     = 3;
  localparam logic              DEF_RST_OVERLAP = 1'b1;

  // Widest pattern len_mask() can describe; MAX_LEN must not exceed it.
  localparam int                MASK_W          = 32;

  typedef enum logic {
    OVL_RESTART = 1'b0,
    OVL_ALLOW   = 1'b1
  } overlap_e;

  // Low-order mask with the bottom 'len' bits set; callers cast down to MAX_LEN.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational masked comparator: hit when the low len bits of window equal pattern.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] window_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               hit_o
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask  = MAX_LEN'(len_mask(32'(len_i)));
    hit_o = ((window_i ^ pattern_i) & mask) == '0;
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with Mealy and registered match flags
// and a saturating detection counter.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter  int                 MAX_LEN     = DEF_MAX_LEN,
  parameter  int                 CNT_W       = DEF_CNT_W,
  parameter  logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter  int                 RST_LEN     = DEF_RST_LEN,
  parameter  logic               RST_OVERLAP = DEF_RST_OVERLAP,
  localparam int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_we_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               cnt_clr_i,
  input  logic               valid_i,
  input  logic               data_i,
  output logic               seq_det_o,
  output logic               seq_det_q_o,
  output logic [CNT_W-1:0]   det_cnt_o
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  if (MAX_LEN < 2 || MAX_LEN > MASK_W) begin : g_bad_max_len
    $error("seq_det_prog: MAX_LEN out of supported range");
  end

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  overlap_e           overlap_q, overlap_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_reg_q, det_reg_d;
  logic [CNT_W-1:0]   det_cnt_q, det_cnt_d;

  logic [MAX_LEN-1:0] window;
  logic [LEN_W-1:0]   cfg_len_clamped;
  logic               hit;
  logic               fill_ok;
  logic               seq_det;

  assign window = {hist_q, data_i};

  seq_det_match #(
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .window_i  (window),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .hit_o     (hit)
  );

  // NOTE: every variable in this block gets a default first, so no latch is inferred
  // on paths that do not assign it.
  always_comb begin
    cfg_len_clamped = (cfg_len_i > MAX_LEN_L) ? MAX_LEN_L : cfg_len_i;
    // len_q - 1 may wrap when len_q == 0, but that case is masked out below.
    fill_ok         = fill_q >= (len_q - LEN_W'(1));
    seq_det         = rst_n_i & valid_i & ~cfg_we_i & (len_q != '0) & fill_ok & hit;

    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    det_reg_d = seq_det;
    det_cnt_d = det_cnt_q;

    if (cfg_we_i) begin
      pattern_d = cfg_pattern_i;
      len_d     = cfg_len_clamped;
      overlap_d = overlap_e'(cfg_overlap_i);
      hist_d    = '0;
      fill_d    = '0;
    end else if (valid_i) begin
      hist_d = window[MAX_LEN-2:0];
      if (seq_det && overlap_q == OVL_RESTART) begin
        fill_d = '0;
      end else if (fill_q != MAX_LEN_L) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    if (cnt_clr_i || cfg_we_i) begin
      det_cnt_d = '0;
    end else if (seq_det && det_cnt_q != CNT_MAX) begin
      det_cnt_d = det_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pattern_q <= RST_PATTERN;
      len_q     <= RST_LEN_L;
      overlap_q <= overlap_e'(RST_OVERLAP);
      hist_q    <= '0;
      fill_q    <= '0;
      det_reg_q <= 1'b0;
      det_cnt_q <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_reg_q <= det_reg_d;
      det_cnt_q <= det_cnt_d;
    end
  end

  assign seq_det_o   = seq_det;
  assign seq_det_q_o = det_reg_q;
  assign det_cnt_o   = det_cnt_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog: stimulus queues expected Mealy flags, a monitor checks them.
`timescale 1ns/1ps
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               valid = 1'b0;
  logic               data = 1'b0;

  logic               det, det_q;
  logic [7:0]         cnt;
  logic               det2, det2_q;
  logic [1:0]         cnt2;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  seq_det_prog dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .cnt_clr_i(cnt_clr),
    .valid_i(valid), .data_i(data), .seq_det_o(det), .seq_det_q_o(det_q),
    .det_cnt_o(cnt)
  );

  seq_det_prog #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .cnt_clr_i(cnt_clr),
    .valid_i(valid), .data_i(data), .seq_det_o(det2), .seq_det_q_o(det2_q),
    .det_cnt_o(cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks the Mealy flag whenever a bit is presented, and the registered copy every cycle.
  bit q_exp = 1'b0;
  always @(negedge clk) begin
    bit e;
    if (!rst_n) begin
      check("rst_det", det, 0);
      check("rst_det_q", det_q, 0);
      check("rst_cnt", cnt, 0);
      q_exp = 1'b0;
    end else begin
      check("det_q", det_q, q_exp);
      if (valid && !cfg_we) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
          q_exp = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("det", det, e);
          q_exp = e;
        end
      end else begin
        check("det_idle", det, 0);
        q_exp = 1'b0;
      end
    end
  end

  task automatic send(input logic d, input bit exp, input logic clr = 1'b0);
    @(posedge clk); #1;
    cfg_we = 1'b0; valid = 1'b1; data = d; cnt_clr = clr;
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n, input bit rnd = 1'b0);
    repeat (n) begin
      @(posedge clk); #1;
      cfg_we = 1'b0; valid = 1'b0; cnt_clr = 1'b0;
      data = rnd ? 1'($urandom) : 1'b0;
    end
  endtask

  // The concurrent valid bit must be discarded by the DUT.
  task automatic cfg(input logic [7:0] pat, input logic [LEN_W-1:0] len, input logic ov);
    @(posedge clk); #1;
    cfg_we = 1'b1; valid = 1'b1; data = 1'b1; cnt_clr = 1'b0;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
  endtask

  task automatic send_vec(input logic [31:0] bits, input logic [31:0] hits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], hits[i]);
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clk);
    check({name, "_cnt8"}, cnt, e1);
    check({name, "_cnt2"}, cnt2, e2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset defaults: 101, len 3, overlap.
    send_vec(32'b10101, 32'b00101, 5);
    idle(1);
    chk_cnt("t1", 2, 2);

    // Non-overlapping 8-bit pattern.
    cfg(8'b1101_0011, 4'd8, 1'b0);
    send_vec(32'b1101_0011_1101_0011, 32'b0000_0001_0000_0001, 16);
    idle(1);
    chk_cnt("t2", 2, 2);

    // Pattern 11: restart vs overlap.
    cfg(8'b0000_0011, 4'd2, 1'b0);
    send_vec(32'b1111, 32'b0101, 4);
    cfg(8'b0000_0011, 4'd2, 1'b1);
    send_vec(32'b1111, 32'b0111, 4);
    idle(1);
    chk_cnt("t3", 3, 3);

    // Gaps with random data do not break a partial match.
    cfg(8'b0000_0101, 4'd3, 1'b1);
    send(1'b1, 1'b0); idle(3, 1'b1);
    send(1'b0, 1'b0); idle(3, 1'b1);
    send(1'b1, 1'b1); idle(3, 1'b1);

    // Length 0 disables detection.
    cfg(8'b0000_0000, 4'd0, 1'b1);
    for (int i = 0; i < 32; i++) send(1'($urandom_range(0, 1)), 1'b0);
    idle(1);
    chk_cnt("t5a", 0, 0);

    // Length 15 clamps to 8.
    cfg(8'b1101_0011, 4'd15, 1'b0);
    send_vec(32'b1101_0011_1101_0011, 32'b0000_0001_0000_0001, 16);
    idle(1);
    chk_cnt("t5b", 2, 2);

    // Counter saturation, then clear coinciding with a hit.
    cfg(8'b0000_0011, 4'd2, 1'b1);
    send_vec(32'b111111, 32'b011111, 6);
    idle(1);
    chk_cnt("t6_sat", 5, 3);
    send(1'b1, 1'b1, 1'b1);
    idle(1);
    chk_cnt("t6_clr", 0, 0);
    send(1'b1, 1'b1);
    idle(1);
    chk_cnt("t6_resume", 1, 1);

    // Reset mid-pattern loses the partial match.
    cfg(8'b0000_0101, 4'd3, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_vec(32'b101, 32'b001, 3);
    idle(2);
    chk_cnt("t7", 1, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
